hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and flush controller for the 5-stage core. It sits beside the decode stage and tracks pending register writes in a 32-entry scoreboard. From that and the stage inputs it decides each cycle whether the ID instruction issues into id_ex, stalls, or is squashed. It also sequences PC redirects and the multi-cycle fetch flush after a taken branch or jump resolved in EX.

## Interface
- `FLUSH_CYCLES`, default 2: cycles `o_if_id_flush` stays asserted per redirect, counting the redirect cycle; legal range 1..7.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_id_valid`  in  1  ID holds a valid instruction.
- `i_rs1_addr` / `i_rs2_addr`  in  5 each  source register addresses.
- `i_rs1_used` / `i_rs2_used`  in  1 each  the instruction reads rs1 / rs2.
- `i_rd_addr`  in  5  destination register.
- `i_rd_we`  in  1  the instruction writes rd.
- `i_wb_we`  in  1  writeback retires a register write this cycle.
- `i_wb_addr`  in  5  writeback destination.
- `i_ex_redirect`  in  1  EX resolved a taken branch or jump.
- `i_ex_target`  in  32  redirect target PC.
- `i_mem_busy`  in  1  memory stage is stalled; freeze the pipe.
- `o_pc_we`  out  1  PC register update enable.
- `o_pc_redirect`  out  1  load `o_pc_target` instead of PC+4.
- `o_pc_target`  out  32  redirect PC.
- `o_if_id_hold`  out  1  if_id keeps its contents.
- `o_if_id_flush`  out  1  if_id loads a NOP/invalid.
- `o_id_ex_hold`  out  1  id_ex keeps its contents.
- `o_id_ex_bubble`  out  1  id_ex loads a NOP/invalid.
- `o_issue`  out  1  the ID instruction moves to id_ex this cycle.
- `o_busy_mask`  out  32  registered scoreboard; bit0 is always 0.
- `o_flushing`  out  1  FSM is in FLUSH.

## Operation
- State: `pend[31:1]`, FSM {IDLE, FLUSH}, 3-bit `cnt`.
- Effective pending set: `pend_eff = pend & ~(i_wb_we ? onehot(i_wb_addr) : 0)`. A register retiring this cycle is not a hazard.
- Register 0 is never pending, never hazards, and is never set.
- `raw = i_id_valid & ((i_rs1_used & rs1≠0 & pend_eff[rs1]) | (i_rs2_used & rs2≠0 & pend_eff[rs2]))`.
- `waw = i_id_valid & i_rd_we & rd≠0 & pend_eff[rd]`.
- `stall = raw | waw`.
- Cases are evaluated in priority order, first match wins. All outputs not listed are 0. `o_pc_target = i_ex_target` always.
  1. `i_mem_busy`: `o_if_id_hold = 1`, `o_id_ex_hold = 1`, `o_pc_we = 0`. The redirect is ignored (EX holds it until busy drops). The FSM and `cnt` are frozen.
  2. `i_ex_redirect`: `o_pc_we = 1`, `o_pc_redirect = 1`, `o_if_id_flush = 1`, `o_id_ex_bubble = 1`.
     - If `FLUSH_CYCLES > 1`: next state FLUSH, `cnt ← FLUSH_CYCLES − 2`.
     - A redirect arriving while in FLUSH restarts the count the same way.
  3. State FLUSH: `o_pc_we = 1`, `o_if_id_flush = 1`, `o_id_ex_bubble = 1`. If `cnt == 0`, go to IDLE; otherwise `cnt` decrements.
  4. `stall`: `o_pc_we = 0`, `o_if_id_hold = 1`, `o_id_ex_bubble = 1`.
  5. Otherwise: `o_pc_we = 1`, `o_issue = i_id_valid`.
- Scoreboard next value: `pend ← pend_eff | (o_issue & i_rd_we & rd≠0 ? onehot(rd) : 0)`.
  - Writeback clears apply in every case, including during `mem_busy` and flush.
  - A set in the same cycle as a clear of the same register wins.
- `o_flushing = (state == FLUSH)`.

## Timing
- Reset is asynchronous: `pend = 0`, state IDLE, `cnt = 0` immediately. While `i_reset` is high, every output is 0, including `o_pc_we` and `o_pc_target`.
- Decision outputs are combinational from inputs and state, with zero-cycle latency.
- `o_busy_mask` and `o_flushing` are registered and reflect state after the last edge.
- An issued write is visible as a hazard to the next ID instruction (one cycle later). Clearing via writeback takes effect in the same cycle.
- Redirect to first fetched-valid instruction in ID: `FLUSH_CYCLES + 1` cycles.
- Reset asserted mid-FLUSH aborts the flush. After release the FSM is IDLE with an empty scoreboard.

## Test plan
- RAW bypass:
  - Issue rd=5 with `i_rd_we`; next cycle `i_rs1_addr=5`, `i_rs1_used` → stall (`o_pc_we=0`, `o_if_id_hold=1`, `o_id_ex_bubble=1`), `o_busy_mask=0x20`.
  - Assert `i_wb_we`, `i_wb_addr=5` → `o_issue=1` the same cycle; mask is 0 after the edge.
- x0: issue rd=0 with `i_rd_we` → mask stays 0; `i_rs2_addr=0` with `i_rs2_used` → never stalls.
- WAW: with `pend[7]` set, ID has rd=7 and `i_rd_we` → stalls. Writeback of x7 → issues; mask is 0x80 again after the edge.
- Redirect, `FLUSH_CYCLES=2`, `i_ex_target=0x80`:
  - Cycle 0: `o_pc_redirect=1`, `o_pc_target=0x80`, flush, bubble.
  - Cycle 1: `o_flushing=1`, flush.
  - Cycle 2: IDLE, `o_issue=1`.
  - A second redirect in cycle 1 extends flushing through cycle 2.
- `i_mem_busy` with `i_ex_redirect` for 3 cycles → no `o_pc_redirect`, `o_pc_we=0`, both holds high. A writeback of x3 during busy clears `pend[3]`. When busy drops, the redirect takes effect.
- Assert `i_reset` mid-flush with mask 0x0000_0F00 → mask 0, `o_flushing=0`, all outputs 0 immediately (before any clock edge).

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and flush controller for the 5-stage core: a 32-entry pending-write scoreboard
// plus a two-state redirect/flush sequencer, deciding issue/stall/squash of the ID instruction.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_id_valid,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    input  logic        i_rs1_used,
    input  logic        i_rs2_used,
    input  logic [4:0]  i_rd_addr,
    input  logic        i_rd_we,
    input  logic        i_wb_we,
    input  logic [4:0]  i_wb_addr,
    input  logic        i_ex_redirect,
    input  logic [31:0] i_ex_target,
    input  logic        i_mem_busy,
    output logic        o_pc_we,
    output logic        o_pc_redirect,
    output logic [31:0] o_pc_target,
    output logic        o_if_id_hold,
    output logic        o_if_id_flush,
    output logic        o_id_ex_hold,
    output logic        o_id_ex_bubble,
    output logic        o_issue,
    output logic [31:0] o_busy_mask,
    output logic        o_flushing
);

    typedef enum logic {IDLE, FLUSH} state_t;

    // Remaining FLUSH cycles after the one following the redirect cycle.
    localparam logic [2:0] CNT_INIT = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic [31:1] pend, pend_nxt;

    logic [31:0] wb_clr;
    logic [31:0] pend_eff;
    logic [31:0] rd_set;
    logic        raw, waw, stall;

    always_comb begin
        wb_clr   = i_wb_we ? (32'd1 << i_wb_addr) : 32'd0;
        pend_eff = {pend, 1'b0} & ~wb_clr;
        raw = i_id_valid & ((i_rs1_used & (i_rs1_addr != 5'd0) & pend_eff[i_rs1_addr]) |
                            (i_rs2_used & (i_rs2_addr != 5'd0) & pend_eff[i_rs2_addr]));
        waw = i_id_valid & i_rd_we & (i_rd_addr != 5'd0) & pend_eff[i_rd_addr];
        stall = raw | waw;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
            pend  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
        end
    end

    // Every decision output is forced low while reset is asserted.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        o_pc_we        = 1'b0;
        o_pc_redirect  = 1'b0;
        o_pc_target    = 32'd0;
        o_if_id_hold   = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_hold   = 1'b0;
        o_id_ex_bubble = 1'b0;
        o_issue        = 1'b0;
        if (!i_reset) begin
            o_pc_target = i_ex_target;
            if (i_mem_busy) begin
                o_if_id_hold = 1'b1;
                o_id_ex_hold = 1'b1;
            end else if (i_ex_redirect) begin
                o_pc_we        = 1'b1;
                o_pc_redirect  = 1'b1;
                o_if_id_flush  = 1'b1;
                o_id_ex_bubble = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = CNT_INIT;
                end else begin
                    state_nxt = IDLE;
                end
            end else if (state == FLUSH) begin
                o_pc_we        = 1'b1;
                o_if_id_flush  = 1'b1;
                o_id_ex_bubble = 1'b1;
                if (cnt == 3'd0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end else if (stall) begin
                o_if_id_hold   = 1'b1;
                o_id_ex_bubble = 1'b1;
            end else begin
                o_pc_we = 1'b1;
                o_issue = i_id_valid;
            end
        end
    end

    // A same-cycle set of a register beats its writeback clear.
    always_comb begin
        rd_set   = (o_issue & i_rd_we & (i_rd_addr != 5'd0)) ? (32'd1 << i_rd_addr) : 32'd0;
        pend_nxt = pend_eff[31:1] | rd_set[31:1];
    end

    assign o_busy_mask = {pend, 1'b0};
    assign o_flushing  = (state == FLUSH);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: the driver pushes a hand-computed output vector per cycle,
// a negedge monitor pops and compares it against the DUT.
module tb_hazard_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_id_valid;
    logic [4:0]  i_rs1_addr, i_rs2_addr, i_rd_addr, i_wb_addr;
    logic        i_rs1_used, i_rs2_used, i_rd_we, i_wb_we;
    logic        i_ex_redirect, i_mem_busy;
    logic [31:0] i_ex_target;
    logic        o_pc_we, o_pc_redirect, o_if_id_hold, o_if_id_flush;
    logic        o_id_ex_hold, o_id_ex_bubble, o_issue, o_flushing;
    logic [31:0] o_pc_target, o_busy_mask;

    // Flag order: pc_we, pc_redirect, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble, issue, flushing
    localparam logic [7:0] F_RUN      = 8'b1000_0000;
    localparam logic [7:0] F_ISS      = 8'b1000_0010;
    localparam logic [7:0] F_STALL    = 8'b0010_0100;
    localparam logic [7:0] F_REDIR    = 8'b1101_0100;
    localparam logic [7:0] F_REDIR_FL = 8'b1101_0101;
    localparam logic [7:0] F_FLUSH    = 8'b1001_0101;
    localparam logic [7:0] F_BUSY     = 8'b0010_1000;
    localparam logic [31:0] TGT       = 32'h0000_0080;

    logic [71:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_fails  = 0;

    hazard_ctrl #(.FLUSH_CYCLES(2)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_id_valid(i_id_valid),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
        .i_rs1_used(i_rs1_used), .i_rs2_used(i_rs2_used),
        .i_rd_addr(i_rd_addr), .i_rd_we(i_rd_we),
        .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr),
        .i_ex_redirect(i_ex_redirect), .i_ex_target(i_ex_target),
        .i_mem_busy(i_mem_busy),
        .o_pc_we(o_pc_we), .o_pc_redirect(o_pc_redirect), .o_pc_target(o_pc_target),
        .o_if_id_hold(o_if_id_hold), .o_if_id_flush(o_if_id_flush),
        .o_id_ex_hold(o_id_ex_hold), .o_id_ex_bubble(o_id_ex_bubble),
        .o_issue(o_issue), .o_busy_mask(o_busy_mask), .o_flushing(o_flushing)
    );

    // clock / reset
    always #5 i_clk = ~i_clk;

    function automatic logic [71:0] mk(input logic [7:0] f, input logic [31:0] m,
                                       input logic [31:0] t);
        return {f, m, t};
    endfunction

    // driver tasks
    task automatic clr_in();
        i_id_valid = 0; i_rs1_addr = 0; i_rs2_addr = 0; i_rs1_used = 0; i_rs2_used = 0;
        i_rd_addr = 0; i_rd_we = 0; i_wb_we = 0; i_wb_addr = 0;
        i_ex_redirect = 0; i_mem_busy = 0; i_ex_target = TGT;
    endtask

    task automatic step(input string nm, input logic [71:0] e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge i_clk);
        #1;
    endtask

    // scoreboard monitor
    always @(negedge i_clk) begin
        if (exp_q.size() > 0) begin
            logic [71:0] e, a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {o_pc_we, o_pc_redirect, o_if_id_hold, o_if_id_flush, o_id_ex_hold,
                  o_id_ex_bubble, o_issue, o_flushing, o_busy_mask, o_pc_target};
            n_checks++;
            if (a !== e) begin
                n_fails++;
                $display("FAIL %s: got flags=%b mask=%h tgt=%h, expected flags=%b mask=%h tgt=%h",
                         nm, a[71:64], a[63:32], a[31:0], e[71:64], e[63:32], e[31:0]);
            end
        end
    end

    initial begin
        clr_in();
        i_reset = 1;
        @(posedge i_clk); #1;
        step("reset", mk(8'h00, 32'h0, 32'h0));
        i_reset = 0;

        // RAW on x5, cleared by same-cycle writeback
        clr_in(); i_id_valid = 1; i_rd_addr = 5; i_rd_we = 1;
        step("issue_r5", mk(F_ISS, 32'h0, TGT));
        clr_in(); i_id_valid = 1; i_rs1_addr = 5; i_rs1_used = 1;
        step("raw_r5", mk(F_STALL, 32'h20, TGT));
        i_wb_we = 1; i_wb_addr = 5;
        step("raw_wb5", mk(F_ISS, 32'h20, TGT));

        // x0 is never tracked
        clr_in(); i_id_valid = 1; i_rd_addr = 0; i_rd_we = 1; i_rs2_addr = 0; i_rs2_used = 1;
        step("x0_issue", mk(F_ISS, 32'h0, TGT));
        clr_in();
        step("x0_mask", mk(F_RUN, 32'h0, TGT));

        // WAW on x7
        clr_in(); i_id_valid = 1; i_rd_addr = 7; i_rd_we = 1;
        step("issue_r7", mk(F_ISS, 32'h0, TGT));
        step("waw_r7", mk(F_STALL, 32'h80, TGT));
        i_wb_we = 1; i_wb_addr = 7;
        step("waw_wb7", mk(F_ISS, 32'h80, TGT));
        clr_in(); i_wb_we = 1; i_wb_addr = 7;
        step("waw_after", mk(F_RUN, 32'h80, TGT));

        // redirect with FLUSH_CYCLES=2
        clr_in(); i_id_valid = 1; i_rd_addr = 3; i_rd_we = 1; i_ex_redirect = 1;
        step("redir_c0", mk(F_REDIR, 32'h0, TGT));
        i_ex_redirect = 0;
        step("redir_c1", mk(F_FLUSH, 32'h0, TGT));
        step("redir_c2", mk(F_ISS, 32'h0, TGT));

        // second redirect during FLUSH extends it
        clr_in(); i_ex_redirect = 1;
        step("redir2_c0", mk(F_REDIR, 32'h08, TGT));
        step("redir2_c1", mk(F_REDIR_FL, 32'h08, TGT));
        i_ex_redirect = 0;
        step("redir2_c2", mk(F_FLUSH, 32'h08, TGT));
        step("redir2_c3", mk(F_RUN, 32'h08, TGT));

        // mem_busy freezes everything but writeback clears
        clr_in(); i_mem_busy = 1; i_ex_redirect = 1; i_id_valid = 1; i_rs1_addr = 3; i_rs1_used = 1;
        step("busy_0", mk(F_BUSY, 32'h08, TGT));
        i_wb_we = 1; i_wb_addr = 3;
        step("busy_1", mk(F_BUSY, 32'h08, TGT));
        i_wb_we = 0;
        step("busy_2", mk(F_BUSY, 32'h0, TGT));
        clr_in(); i_ex_redirect = 1;
        step("busy_drop", mk(F_REDIR, 32'h0, TGT));
        i_ex_redirect = 0;
        step("busy_flush", mk(F_FLUSH, 32'h0, TGT));

        // fill x8..x11, then reset in the middle of a flush
        for (int k = 0; k < 4; k++) begin
            logic [31:0] m;
            m = 32'h0;
            for (int j = 0; j < k; j++) m[8 + j] = 1'b1;
            clr_in(); i_id_valid = 1; i_rd_addr = 5'(8 + k); i_rd_we = 1;
            step($sformatf("fill_%0d", k), mk(F_ISS, m, TGT));
        end
        clr_in(); i_ex_redirect = 1;
        step("pre_rst_redir", mk(F_REDIR, 32'h0F00, TGT));
        clr_in(); i_reset = 1;
        step("rst_mid_flush", mk(8'h00, 32'h0, 32'h0));
        i_reset = 0; i_id_valid = 1; i_rs1_addr = 8; i_rs1_used = 1;
        step("post_rst", mk(F_ISS, 32'h0, TGT));
        clr_in();
        step("post_rst_idle", mk(F_RUN, 32'h0, TGT));

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge i_clk);
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
